alu_multicycle: RTL and testbench

//  Parametrised successor to the datapath ALU: registered, handshaked ALU for the execute stage.
//  - Single-cycle ops: AND, OR, ADD, SUB, SLL, SRL, SLTU. Throughput is one per cycle.
//  - Iterative ops: unsigned MULU (shift-add) and DIVU (restoring). Each takes WIDTH cycles.
//  - The control FSM stalls the pipeline on in_ready=0 while an iterative op is running.

---
 rtl/alu_multicycle.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle
//   Registered, handshaked execute-stage ALU.
//   Single-cycle ops (AND, OR, ADD, SUB, SLL, SRL, SLTU) complete at the accept
//   edge. Iterative ops (MULU shift-add, DIVU restoring) run for WIDTH cycles
//   while in_ready is held low.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   operands/opcode valid
//   in_ready   block can accept (IDLE and not in reset)
//   aluCtrl    4-bit opcode
//   input1     operand A
//   input2     operand B
//   result     registered result (low half / quotient)
//   result_hi  MULU high half, DIVU remainder, else 0
//   zero       registered (input1 == input2) of the accepted op
//   done       one-cycle pulse when the outputs above are updated
//   illegal    registered: accepted opcode undefined or disabled
module alu_multicycle #(
    parameter int WIDTH         = 32,
    parameter int ENABLE_MULDIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluCtrl,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             done,
    output logic             illegal
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e           state_q, state_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] resultHi_q, resultHi_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic             illegal_q, illegal_d;

    // Iterative working set: hiWork is the partial product high half or the
    // running remainder, loWork is the multiplier being consumed or the
    // dividend being turned into the quotient.
    logic [WIDTH-1:0] hiWork_q, hiWork_d;
    logic [WIDTH-1:0] loWork_q, loWork_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic             isDiv_q, isDiv_d;
    logic             zeroPend_q, zeroPend_d;

    logic [WIDTH-1:0] singleLo;
    logic [WIDTH-1:0] singleHi;
    logic             decIllegal;
    logic             decIter;
    logic             decDiv;
    logic [SW-1:0]    shamt;

    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic             divGe;
    logic [WIDTH-1:0] divDiff;
    logic [WIDTH-1:0] iterHi;
    logic [WIDTH-1:0] iterLo;

    assign in_ready  = (state_q == IDLE) && !reset;
    assign result    = result_q;
    assign result_hi = resultHi_q;
    assign zero      = zero_q;
    assign done      = done_q;
    assign illegal   = illegal_q;

    assign shamt = input2[SW-1:0];

    // Opcode decode and single-cycle results. DIVU by zero is resolved here
    // so it never enters the iterative path.
    always_comb begin
        singleLo   = '0;
        singleHi   = '0;
        decIllegal = 1'b0;
        decIter    = 1'b0;
        decDiv     = 1'b0;
        case (aluCtrl)
            4'b0000: singleLo = input1 & input2;
            4'b0001: singleLo = input1 | input2;
            4'b0010: singleLo = input1 + input2;
            4'b0011: singleLo = input1 - input2;
            4'b0100: singleLo = input1 << shamt;
            4'b0101: singleLo = input1 >> shamt;
            4'b0110: singleLo = {{(WIDTH-1){1'b0}}, (input1 < input2)};
            4'b0111: begin
                if (ENABLE_MULDIV != 0) decIter = 1'b1;
                else                    decIllegal = 1'b1;
            end
            4'b1000: begin
                if (ENABLE_MULDIV == 0) begin
                    decIllegal = 1'b1;
                end else if (input2 == '0) begin
                    singleLo = '1;
                    singleHi = input1;
                end else begin
                    decIter = 1'b1;
                    decDiv  = 1'b1;
                end
            end
            default: decIllegal = 1'b1;
        endcase
    end

    // One iteration of each algorithm. Multiply adds the multiplicand when the
    // current multiplier bit is set and shifts the pair right; divide shifts
    // the next dividend bit into the remainder and subtracts when it fits.
    // The remainder stays below the divisor, so the difference fits in WIDTH.
    always_comb begin
        mulSum   = loWork_q[0] ? ({1'b0, hiWork_q} + {1'b0, opB_q}) : {1'b0, hiWork_q};
        divShift = {hiWork_q, loWork_q[WIDTH-1]};
        divGe    = (divShift >= {1'b0, opB_q});
        divDiff  = divShift[WIDTH-1:0] - opB_q;
        if (isDiv_q) begin
            iterHi = divGe ? divDiff : divShift[WIDTH-1:0];
            iterLo = {loWork_q[WIDTH-2:0], divGe};
        end else begin
            iterHi = mulSum[WIDTH:1];
            iterLo = {mulSum[0], loWork_q[WIDTH-1:1]};
        end
    end

    // Control FSM and output next-state. IDLE writes single-cycle results at
    // the accept edge; BUSY iterates and publishes on the counter==0 edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        resultHi_d = resultHi_q;
        zero_d     = zero_q;
        done_d     = 1'b0;
        illegal_d  = illegal_q;
        hiWork_d   = hiWork_q;
        loWork_d   = loWork_q;
        opB_d      = opB_q;
        isDiv_d    = isDiv_q;
        zeroPend_d = zeroPend_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (decIter) begin
                        state_d    = BUSY;
                        cnt_d      = CNT_LAST;
                        hiWork_d   = '0;
                        loWork_d   = input1;
                        opB_d      = input2;
                        isDiv_d    = decDiv;
                        zeroPend_d = (input1 == input2);
                    end else begin
                        result_d   = singleLo;
                        resultHi_d = singleHi;
                        zero_d     = (input1 == input2);
                        illegal_d  = decIllegal;
                        done_d     = 1'b1;
                    end
                end
            end
            BUSY: begin
                hiWork_d = iterHi;
                loWork_d = iterLo;
                if (cnt_q == '0) begin
                    state_d    = IDLE;
                    result_d   = iterLo;
                    resultHi_d = iterHi;
                    zero_d     = zeroPend_q;
                    illegal_d  = 1'b0;
                    done_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any iteration in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            result_q   <= '0;
            resultHi_q <= '0;
            zero_q     <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            hiWork_q   <= '0;
            loWork_q   <= '0;
            opB_q      <= '0;
            isDiv_q    <= 1'b0;
            zeroPend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            resultHi_q <= resultHi_d;
            zero_q     <= zero_d;
            done_q     <= done_d;
            illegal_q  <= illegal_d;
            hiWork_q   <= hiWork_d;
            loWork_q   <= loWork_d;
            opB_q      <= opB_d;
            isDiv_q    <= isDiv_d;
            zeroPend_q <= zeroPend_d;
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle
//   Directed self-checking bench for alu_multicycle (WIDTH=32, MULDIV enabled).
module tb_alu_multicycle;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         inValid;
    logic         inReady;
    logic [3:0]   aluCtrl;
    logic [W-1:0] input1;
    logic [W-1:0] input2;
    logic [W-1:0] result;
    logic [W-1:0] resultHi;
    logic         zero;
    logic         done;
    logic         illegal;

    int checksTotal  = 0;
    int checksPassed = 0;
    int checksFailed = 0;
    int cycles;
    int readyLow;

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    alu_multicycle #(
        .WIDTH(W),
        .ENABLE_MULDIV(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(inValid),
        .in_ready(inReady),
        .aluCtrl(aluCtrl),
        .input1(input1),
        .input2(input2),
        .result(result),
        .result_hi(resultHi),
        .zero(zero),
        .done(done),
        .illegal(illegal)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checksTotal++;
        assert (obs === exp) checksPassed++;
        else begin
            checksFailed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present an operation on the falling edge so it is stable at the next rise.
    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        inValid = 1'b1;
        aluCtrl = op;
        input1  = a;
        input2  = b;
    endtask

    task automatic dropValid();
        @(negedge clk);
        inValid = 1'b0;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until done (bounded) and how many sampled cycles had in_ready low.
    task automatic waitDone(output int cyc, output int rl);
        cyc = 0;
        rl  = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (inReady === 1'b0) rl++;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        reset   = 1'b1;
        inValid = 1'b0;
        aluCtrl = 4'b0000;
        input1  = '0;
        input2  = '0;

        stepEdge();
        checkOutput("rst_result", 64'(result), 64'h0);
        checkOutput("rst_result_hi", 64'(resultHi), 64'h0);
        checkOutput("rst_done", 64'(done), 64'h0);
        checkOutput("rst_illegal", 64'(illegal), 64'h0);
        checkOutput("rst_in_ready", 64'(inReady), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // ADD wraparound
        applyStimulus(4'b0010, 32'hFFFF_FFFF, 32'h1);
        #1;
        checkOutput("add_ready_before", 64'(inReady), 64'h1);
        stepEdge();
        checkOutput("add_done", 64'(done), 64'h1);
        checkOutput("add_result", 64'(result), 64'h0);
        checkOutput("add_zero", 64'(zero), 64'h0);
        checkOutput("add_in_ready", 64'(inReady), 64'h1);

        // Back-to-back SUB then SLTU
        applyStimulus(4'b0011, 32'd5, 32'd5);
        stepEdge();
        checkOutput("sub_done", 64'(done), 64'h1);
        checkOutput("sub_result", 64'(result), 64'h0);
        checkOutput("sub_zero", 64'(zero), 64'h1);
        applyStimulus(4'b0110, 32'd3, 32'd7);
        stepEdge();
        checkOutput("sltu_done", 64'(done), 64'h1);
        checkOutput("sltu_result", 64'(result), 64'h1);
        checkOutput("sltu_zero", 64'(zero), 64'h0);
        dropValid();
        stepEdge();
        checkOutput("idle_done_low", 64'(done), 64'h0);
        checkOutput("idle_hold_result", 64'(result), 64'h1);

        // MULU 0xFFFFFFFF * 2
        applyStimulus(4'b0111, 32'hFFFF_FFFF, 32'd2);
        stepEdge();
        checkOutput("mul_accept_ready", 64'(inReady), 64'h0);
        checkOutput("mul_accept_done", 64'(done), 64'h0);
        dropValid();
        waitDone(cycles, readyLow);
        checkOutput("mul_latency", 64'(cycles), 64'd32);
        checkOutput("mul_ready_low", 64'(readyLow), 64'd32);
        checkOutput("mul_result", 64'(result), 64'hFFFF_FFFE);
        checkOutput("mul_result_hi", 64'(resultHi), 64'h1);
        checkOutput("mul_in_ready", 64'(inReady), 64'h1);
        stepEdge();
        checkOutput("mul_done_pulse", 64'(done), 64'h0);

        // DIVU 100 / 7
        applyStimulus(4'b1000, 32'd100, 32'd7);
        stepEdge();
        checkOutput("div_accept_ready", 64'(inReady), 64'h0);
        dropValid();
        waitDone(cycles, readyLow);
        checkOutput("div_latency", 64'(cycles), 64'd32);
        checkOutput("div_quotient", 64'(result), 64'd14);
        checkOutput("div_remainder", 64'(resultHi), 64'd2);

        // DIVU by zero completes in one cycle
        applyStimulus(4'b1000, 32'd9, 32'd0);
        stepEdge();
        checkOutput("div0_done", 64'(done), 64'h1);
        checkOutput("div0_result", 64'(result), 64'hFFFF_FFFF);
        checkOutput("div0_result_hi", 64'(resultHi), 64'd9);
        checkOutput("div0_illegal", 64'(illegal), 64'h0);
        checkOutput("div0_in_ready", 64'(inReady), 64'h1);

        // SLL uses only the low log2(W) bits of input2
        applyStimulus(4'b0100, 32'd1, 32'h21);
        stepEdge();
        checkOutput("sll_result", 64'(result), 64'd2);
        checkOutput("sll_result_hi", 64'(resultHi), 64'h0);

        // SRL
        applyStimulus(4'b0101, 32'h8000_0000, 32'd31);
        stepEdge();
        checkOutput("srl_result", 64'(result), 64'h1);

        // Illegal opcode, then a legal op clears illegal
        applyStimulus(4'b1111, 32'd4, 32'd6);
        stepEdge();
        checkOutput("ill_done", 64'(done), 64'h1);
        checkOutput("ill_flag", 64'(illegal), 64'h1);
        checkOutput("ill_result", 64'(result), 64'h0);
        applyStimulus(4'b0010, 32'd7, 32'd7);
        stepEdge();
        checkOutput("ill_clear", 64'(illegal), 64'h0);
        checkOutput("ill_clear_result", 64'(result), 64'd14);
        checkOutput("ill_clear_zero", 64'(zero), 64'h1);

        // Reset during MULU with in_valid held
        applyStimulus(4'b0111, 32'd3, 32'd4);
        stepEdge();
        checkOutput("abort_accept_ready", 64'(inReady), 64'h0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("abort_result", 64'(result), 64'h0);
        checkOutput("abort_zero", 64'(zero), 64'h0);
        checkOutput("abort_in_ready", 64'(inReady), 64'h0);
        stepEdge();
        checkOutput("abort_done", 64'(done), 64'h0);
        checkOutput("abort_ready_in_reset", 64'(inReady), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("release_ready", 64'(inReady), 64'h1);
        stepEdge();
        checkOutput("reaccept_ready", 64'(inReady), 64'h0);
        checkOutput("reaccept_done", 64'(done), 64'h0);
        dropValid();
        waitDone(cycles, readyLow);
        checkOutput("reaccept_latency", 64'(cycles), 64'd32);
        checkOutput("reaccept_result", 64'(result), 64'd12);
        checkOutput("reaccept_result_hi", 64'(resultHi), 64'h0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
